// File: rtl/rvx_pkg.sv
// Shared RVX10 fetch-side types and constants.
// One queue entry pairs a fetched word with the address it came from.
package rvx_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
// The head entry is read straight from storage, so it is meaningful only when count != 0.
module fetch_fifo
    import rvx_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: every always_comb output is given its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // The issue-side reservation must make overflow impossible.
    assert property (@(posedge clk) disable iff (!reset)
        !(push && !flush && count_q == CW'(DEPTH)));

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction prefetch buffer: sequential fetch over req/gnt/rvalid, queued delivery to decode,
// and a redirect that flushes the queue and kills responses still in flight.
module ifetch_buffer
    import rvx_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = rvx_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   kill_q, kill_d;

    logic [CW-1:0]   count;
    logic [CW:0]     inflight;
    logic [XLEN-1:0] target_pc;
    logic            accept, resp_ok, push, pop;
    fetch_entry_t    head, push_entry;

    assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign imem_addr   = fetch_pc_q;
    assign push_entry  = '{pc: resp_pc_q, instr: imem_rdata};

    always_comb begin
        // Queued entries plus requests in flight reserve every slot, so a response always finds room.
        inflight = {1'b0, count} + {1'b0, outstanding_q};
        imem_req = reset & ~redirect & (inflight < (CW + 1)'(DEPTH));
        accept   = imem_req & imem_gnt;
        // A response with nothing outstanding is a leftover from before reset and is dropped.
        resp_ok  = imem_rvalid & (outstanding_q != '0);
        push     = resp_ok & (kill_q == '0) & ~redirect;
        pop      = instr_valid & ~stall & ~redirect;

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;

        if (accept)  outstanding_d = outstanding_d + CNT_ONE;
        if (resp_ok) outstanding_d = outstanding_d - CNT_ONE;
        if (resp_ok && kill_q != '0) kill_d = kill_q - CNT_ONE;
        if (accept)  fetch_pc_d = fetch_pc_q + PC_STEP;
        if (push)    resp_pc_d  = resp_pc_q + PC_STEP;

        if (redirect) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            kill_d     = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: queue-level reference model compared every cycle,
// an in-order memory responder with programmable latency, and directed scenarios with literal expectations.
module tb_ifetch_buffer;
    import rvx_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        imem_req;
    logic [31:0] imem_addr;

    ifetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
    endfunction

    // ---------------- memory responder ----------------
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    logic [31:0] grant_log[$];
    int          lat = 1;
    int          cyc = 0;
    logic        mem_rv = 1'b0;
    logic [31:0] mem_rd = '0;
    logic        stray = 1'b0;

    assign imem_rvalid = mem_rv | stray;
    assign imem_rdata  = stray ? 32'hDEAD_BEEF : mem_rd;

    initial forever begin
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rv = 1'b1;
            mem_rd = mem_word(pend[0].addr);
        end else begin
            mem_rv = 1'b0;
            mem_rd = '0;
        end
    end

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t        m_q[$];
    int          m_out = 0;
    int          m_kill = 0;
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_resp = RESET_PC;

    // Compare on the falling edge, then advance the model on the rising edge from the sampled inputs.
    initial begin
        logic        s_stall, s_redir, s_gnt, s_rv, s_mrv, s_req, s_exp_req;
        logic [31:0] s_rpc, s_rd, s_addr;
        bit          acc, resp, do_push;
        s_stall = 0; s_redir = 0; s_gnt = 0; s_rv = 0; s_mrv = 0; s_req = 0; s_exp_req = 0;
        s_rpc = '0; s_rd = '0; s_addr = '0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                s_exp_req = !redirect && (m_q.size() + m_out < DEPTH);
                check("instr_valid", instr_valid, m_q.size() != 0);
                check("instr", instr, m_q.size() != 0 ? m_q[0].ins : NOP_INSTR);
                check("instr_pc", instr_pc, m_q.size() != 0 ? m_q[0].pc : 32'h0);
                check("imem_req", imem_req, s_exp_req);
                check("imem_addr", imem_addr, m_fetch);
                s_stall = stall; s_redir = redirect; s_rpc = redirect_pc;
                s_gnt = imem_gnt; s_rv = imem_rvalid; s_mrv = mem_rv; s_rd = imem_rdata;
                s_req = imem_req; s_addr = imem_addr;
            end
            @(posedge clk);
            if (!reset) begin
                m_q.delete(); m_out = 0; m_kill = 0;
                m_fetch = RESET_PC; m_resp = RESET_PC;
                pend.delete();
            end else begin
                if (s_mrv && pend.size() > 0) void'(pend.pop_front());
                if (s_req && s_gnt) begin
                    pend.push_back('{addr: s_addr, due: cyc + lat});
                    grant_log.push_back(s_addr);
                end
                acc = s_exp_req && s_gnt;
                resp = s_rv && (m_out > 0);
                do_push = 0;
                if (resp) begin
                    m_out--;
                    if (m_kill > 0) m_kill--;
                    else do_push = 1;
                end
                if (acc) m_out++;
                if (s_redir) begin
                    m_q.delete();
                    m_kill  = m_out;
                    m_fetch = {s_rpc[31:2], 2'b00};
                    m_resp  = {s_rpc[31:2], 2'b00};
                end else begin
                    if (m_q.size() > 0 && !s_stall) void'(m_q.pop_front());
                    if (do_push) begin
                        m_q.push_back('{pc: m_resp, ins: s_rd});
                        m_resp += 32'd4;
                    end
                    if (acc) m_fetch += 32'd4;
                end
            end
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog expired");
    end

    // Returns at the falling edge where reset is released; the caller drives cycle 1 inputs.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; stray = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit found;
        int g0;

        // 1: streaming, single-cycle memory
        do_reset();
        lat = 1; imem_gnt = 1'b1;
        #3;
        check("t1_req_c1", imem_req, 1'b1);
        check("t1_addr_c1", imem_addr, 32'h0);
        check("t1_valid_c1", instr_valid, 1'b0);
        @(negedge clk); #3;
        check("t1_addr_c2", imem_addr, 32'h4);
        check("t1_valid_c2", instr_valid, 1'b0);
        @(negedge clk); #3;
        check("t1_addr_c3", imem_addr, 32'h8);
        check("t1_valid_c3", instr_valid, 1'b1);
        check("t1_pc_c3", instr_pc, 32'h0);
        check("t1_instr_c3", instr, mem_word(32'h0));
        @(negedge clk); #3;
        check("t1_pc_c4", instr_pc, 32'h4);
        @(negedge clk); #3;
        check("t1_pc_c5", instr_pc, 32'h8);
        repeat (8) @(negedge clk);

        // 2: stall fills the queue, release drains in order
        do_reset();
        lat = 1; imem_gnt = 1'b1; stall = 1'b1;
        g0 = grant_log.size();
        repeat (10) @(negedge clk);
        #3;
        check("t2_grants", grant_log.size() - g0, 4);
        check("t2_req_full", imem_req, 1'b0);
        check("t2_valid_full", instr_valid, 1'b1);
        check("t2_head_pc", instr_pc, 32'h0);
        @(negedge clk);
        stall = 1'b0;
        g0 = grant_log.size();
        for (int i = 0; i < 4; i++) begin
            #3;
            check("t2_drain_pc", instr_pc, 32'(i * 4));
            @(negedge clk);
        end
        #3;
        if (grant_log.size() > g0) check("t2_resume_addr", grant_log[g0], 32'h10);
        else check("t2_resume_missing", 32'h0, 32'h1);
        repeat (4) @(negedge clk);

        // 3: redirect with two requests outstanding, latency 3
        do_reset();
        lat = 3; imem_gnt = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (m_out == 2) begin found = 1; break; end
            @(negedge clk);
        end
        check("t3_setup", found, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h0000_0202;
        #2;
        check("t3_req_in_redirect", imem_req, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        check("t3_valid_after_redirect", instr_valid, 1'b0);
        check("t3_addr_after_redirect", imem_addr, 32'h200);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (instr_valid) begin found = 1; break; end
            @(negedge clk); #3;
        end
        check("t3_first_valid_seen", found, 1'b1);
        check("t3_first_pc", instr_pc, 32'h200);
        check("t3_first_instr", instr, mem_word(32'h200));
        repeat (6) @(negedge clk);

        // 4: redirect coincides with the only response
        do_reset();
        lat = 3; imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (imem_rvalid) begin found = 1; break; end
            @(negedge clk);
        end
        check("t4_setup", found, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        @(negedge clk);
        redirect = 1'b0; imem_gnt = 1'b1;
        #3;
        check("t4_valid_after_redirect", instr_valid, 1'b0);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (instr_valid) begin found = 1; break; end
            @(negedge clk); #3;
        end
        check("t4_first_valid_seen", found, 1'b1);
        check("t4_first_pc", instr_pc, 32'h300);
        repeat (4) @(negedge clk);

        // 5: request held without grant
        do_reset();
        lat = 1; imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            check("t5_req_held", imem_req, 1'b1);
            check("t5_addr_stable", imem_addr, 32'h0);
            check("t5_no_valid", instr_valid, 1'b0);
            @(negedge clk);
        end
        imem_gnt = 1'b1;
        repeat (4) @(negedge clk);

        // 6: asynchronous reset with work in flight, then a stray response
        do_reset();
        lat = 1; imem_gnt = 1'b1; stall = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (m_q.size() == 3 && m_out == 1) begin found = 1; break; end
            @(negedge clk);
        end
        check("t6_setup", found, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", instr_valid, 1'b0);
        check("t6_rst_instr", instr, 32'h0000_0013);
        check("t6_rst_pc", instr_pc, 32'h0);
        check("t6_rst_req", imem_req, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1; imem_gnt = 1'b0; stall = 1'b0; stray = 1'b1;
        #3;
        check("t6_first_req", imem_req, 1'b1);
        check("t6_first_addr", imem_addr, 32'h0);
        @(negedge clk);
        stray = 1'b0;
        #3;
        check("t6_stray_dropped", instr_valid, 1'b0);
        @(negedge clk); #3;
        check("t6_still_empty", instr_valid, 1'b0);
        imem_gnt = 1'b1;
        repeat (6) @(negedge clk);

        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
